dmem_access_unit: RTL and testbench

- MEM-stage engine that drives the data-memory bus from the control word's dmem_read/dmem_write and funct3 fields.
- Sits between the EX/MEM pipeline register and the data cache/memory port.
- Holds the bus request until the memory handshake completes, stalling the pipeline meanwhile.
- Builds byte-enables and store-data lanes; aligns and sign/zero-extends load data for the WB stage.

---
 rtl/dmem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access engine: issues one bus request per load/store,
// stalls the pipeline until dmem_resp (or timeout), and formats load results.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        cw_dmem_read,
  input  logic        cw_dmem_write,
  input  logic [2:0]  cw_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        align_err,
  output logic        timeout_err
);

  // state | meaning
  // IDLE  | no access in flight; a legal access issues the bus request
  // BUSY  | request held on the bus until dmem_resp or timeout
  // DONE  | access finished; pipeline released for exactly one cycle
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        timeout_err_q, timeout_err_d;

  logic        access, illegal, misaligned;
  logic        stall_c, align_err_c;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  always_comb begin
    access     = req_valid & (cw_dmem_read | cw_dmem_write);
    illegal    = (cw_dmem_read & cw_dmem_write)
               | (cw_dmem_read & ((cw_funct3 == 3'b011) | (cw_funct3 == 3'b110) |
                                  (cw_funct3 == 3'b111)))
               | (cw_dmem_write & (cw_funct3 > 3'b010));
    misaligned = ((cw_funct3[1:0] == 2'b10) & (mem_addr[1:0] != 2'b00))
               | ((cw_funct3[1:0] == 2'b01) & mem_addr[0]);
  end

  always_comb begin
    st_mask = 4'b1111;
    st_data = store_data;
    case (cw_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << mem_addr[1:0];
        st_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << mem_addr[1:0];
        st_data = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lanes are picked with the registered address, not the live pipeline one.
  always_comb begin
    ld_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    read_d        = read_q;
    write_d       = write_q;
    wmask_d       = wmask_q;
    wdata_d       = wdata_q;
    f3_d          = f3_q;
    cnt_d         = cnt_q;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    timeout_err_d = 1'b0;
    stall_c       = 1'b0;
    align_err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal | misaligned) begin
            align_err_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = BUSY;
            addr_d  = mem_addr;
            read_d  = cw_dmem_read;
            write_d = cw_dmem_write;
            wmask_d = cw_dmem_write ? st_mask : 4'b0000;
            wdata_d = st_data;
            f3_d    = cw_funct3;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (dmem_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
          if (read_q) begin
            load_data_d  = ld_fmt;
            load_valid_d = 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          read_d        = 1'b0;
          write_d       = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      wmask_q       <= '0;
      wdata_q       <= '0;
      f3_q          <= '0;
      cnt_q         <= '0;
      load_data_q   <= '0;
      load_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      write_q       <= write_d;
      wmask_q       <= wmask_d;
      wdata_q       <= wdata_d;
      f3_q          <= f3_d;
      cnt_q         <= cnt_d;
      load_data_q   <= load_data_d;
      load_valid_q  <= load_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Combinational outputs are forced low while reset is held, even with req_valid high.
  assign stall        = stall_c & rst_n;
  assign align_err    = align_err_c & rst_n;
  assign dmem_address = {addr_q[31:2], 2'b00};
  assign dmem_read    = read_q;
  assign dmem_write   = write_q;
  assign dmem_wmask   = wmask_q;
  assign dmem_wdata   = wdata_q;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver pushes expected bus/completion
// events from a byte-lane reference model; a negedge monitor pops and compares.
module tb_dmem_access_unit;
  localparam int TO_CYC  = 4;
  localparam int K_ISSUE = 0, K_DROP = 1, K_LOAD = 2, K_TO = 3, K_REJ = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, cw_dmem_read, cw_dmem_write;
  logic [2:0]  cw_funct3;
  logic [31:0] mem_addr, store_data;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata, load_data;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [3:0]  dmem_wmask;
  logic        stall, load_valid, align_err, timeout_err;

  ev_t exp_q[$];
  int  checks, errors;
  int  resp_lat;
  logic [31:0] resp_word;
  int  stray_req_n, stray_done_n;
  logic done_flag;

  logic        mon_prev_req, mon_prev_stall, mon_req;
  int          mon_dur;
  logic [31:0] sv_addr, sv_b, sv_wdata;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .cw_dmem_read(cw_dmem_read), .cw_dmem_write(cw_dmem_write),
    .cw_funct3(cw_funct3), .mem_addr(mem_addr), .store_data(store_data),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .align_err(align_err), .timeout_err(timeout_err)
  );

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr);
    if (rd && wr) return 0;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 0;
    if (wr && f3 > 3'd2) return 0;
    return (int'(addr[1:0]) % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_wmask(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << acc_size(f3)) - 1) << addr[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = acc_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [31:0] addr);
    logic [31:0] v, m;
    int sz;
    sz = acc_size(f3);
    v  = word >> (8 * int'(addr[1:0]));
    if (sz < 4) begin
      m = (32'h1 << (8 * sz)) - 32'h1;
      v = v & m;
      if (!f3[2] && v[8*sz-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    req_valid = 1'b0; cw_dmem_read = 1'b0; cw_dmem_write = 1'b0;
    cw_funct3 = 3'b000; mem_addr = 32'h0; store_data = 32'h0;
  endtask

  task automatic stray();
    set_idle();
    stray_req_n = stray_req_n + 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic rv, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] word, input int lat);
    logic s;
    int   cyc;
    logic [3:0] wm;
    if (rv && (rd || wr)) begin
      if (!is_legal(rd, wr, f3, addr)) begin
        push(K_REJ, 0, 0, 0);
      end else begin
        wm = wr ? model_wmask(f3, addr) : 4'b0000;
        push(K_ISSUE, {addr[31:2], 2'b00}, {26'b0, wm, rd, wr}, model_wdata(f3, sd));
        push(K_DROP, (lat == 0) ? TO_CYC : lat, 0, 0);
        if (lat == 0) push(K_TO, 0, 0, 0);
        else if (rd) push(K_LOAD, model_load(word, f3, addr), 0, 0);
      end
    end
    resp_lat = lat; resp_word = word;
    req_valid = rv; cw_dmem_read = rd; cw_dmem_write = wr;
    cw_funct3 = f3; mem_addr = addr; store_data = sd;
    cyc = 0;
    do begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      cyc++;
      if (cyc >= 64) begin
        $display("FAIL stall_bound actual=%0d cycles required=<64", cyc);
        $fatal(1, "pipeline never released");
      end
    end while (s);
    #1;
  endtask

  task automatic reset_mid_access();
    resp_lat = 0;
    push(K_ISSUE, 32'h7008, 32'h2, 32'h0);
    req_valid = 1'b1; cw_dmem_read = 1'b1; cw_dmem_write = 1'b0;
    cw_funct3 = 3'b010; mem_addr = 32'h7008; store_data = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_access(1, 0, 0, 3'b010, 32'h0, 0, 0, 1);
    stray();
  endtask

  initial begin : main
    logic [2:0]  load_f3s [5];
    logic        rv, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          p, lat;
    load_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_n = 1'b0; done_flag = 1'b0;
    resp_lat = -1; resp_word = 0; stray_req_n = 0;
    set_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_access(1, 0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 0, 2);
    do_access(1, 1, 0, 3'b000, 32'h2003, 0, 32'h80AABBCC, 1);
    do_access(1, 1, 0, 3'b100, 32'h2003, 0, 32'h80AABBCC, 1);
    do_access(1, 0, 1, 3'b001, 32'h3002, 32'h00001234, 0, 3);
    do_access(1, 1, 0, 3'b001, 32'h3001, 0, 0, 1);
    do_access(1, 1, 0, 3'b010, 32'h4000, 0, 32'h11223344, 0);
    stray();
    do_access(1, 1, 1, 3'b010, 32'h5000, 32'h55, 0, 1);
    do_access(1, 1, 0, 3'b010, 32'h6000, 0, 32'hCAFEF00D, 1);
    do_access(1, 1, 0, 3'b010, 32'h6004, 0, 32'h0BADBEEF, 1);
    set_idle();
    @(posedge clk);
    #1;
    reset_mid_access();

    for (int i = 0; i < 200; i++) begin
      rv = ($urandom_range(0, 99) >= 5);
      p  = $urandom_range(0, 19);
      rd = (p < 9) || (p == 19);
      wr = (p >= 9 && p < 18) || (p == 19);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        f3 = rd ? load_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(acc_size(f3)) - 32'h1);
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      do_access(rv, rd, wr, f3, addr, $urandom, $urandom, lat);
      if ($urandom_range(0, 7) == 0) stray();
    end

    set_idle();
    repeat (5) @(posedge clk);
    done_flag = 1'b1;
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    int busy_n;
    dmem_resp = 1'b0; dmem_rdata = 32'h0; busy_n = 0; stray_done_n = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (dmem_read || dmem_write)) busy_n++;
      else busy_n = 0;
      dmem_resp = 1'b0;
      if (busy_n != 0 && busy_n == resp_lat) begin
        dmem_resp  = 1'b1;
        dmem_rdata = resp_word;
      end else if (stray_req_n != stray_done_n) begin
        dmem_resp    = 1'b1;
        dmem_rdata   = $urandom;
        stray_done_n = stray_req_n;
      end else begin
        dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=kind%0d a=%h required=no event", kind, a);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          K_ISSUE: begin
            chk("issue_addr", a, e.a);
            chk("issue_mask_rw", b, e.b);
            if (e.b[0]) chk("issue_wdata", c, e.c);
          end
          K_DROP:  chk("busy_cycles", a, e.a);
          K_LOAD:  chk("load_data", a, e.a);
          default: ;
        endcase
      end
    end
  endtask

  initial begin : monitor
    checks = 0; errors = 0;
    mon_prev_req = 1'b0; mon_prev_stall = 1'b0; mon_dur = 0;
    sv_addr = 0; sv_b = 0; sv_wdata = 0;
    forever begin
      @(negedge clk);
      if (done_flag) begin
        chk("leftover_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_bus", {27'b0, dmem_read, dmem_write, dmem_wmask}, 0);
        chk("rst_addr", dmem_address, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_pulses", {28'b0, load_valid, align_err, timeout_err, stall}, 0);
        mon_prev_req = 1'b0;
        mon_dur = 0;
      end else begin
        mon_req = dmem_read | dmem_write;
        if (mon_req) chk("bus_exclusive", {31'b0, dmem_read & dmem_write}, 0);
        if (mon_req && !mon_prev_req) begin
          chk("issue_cycle_stall", {31'b0, mon_prev_stall}, 1);
          sv_addr  = dmem_address;
          sv_b     = {26'b0, dmem_wmask, dmem_read, dmem_write};
          sv_wdata = dmem_wdata;
          mon_dur  = 1;
          observe(K_ISSUE, sv_addr, sv_b, sv_wdata);
        end else if (mon_req) begin
          mon_dur++;
          chk("busy_hold", {26'b0, dmem_wmask, dmem_read, dmem_write} ^ sv_b
                           | (dmem_address ^ sv_addr) | (dmem_wdata ^ sv_wdata), 0);
        end else if (mon_prev_req) begin
          chk("done_stall", {31'b0, stall}, 0);
          observe(K_DROP, mon_dur, 0, 0);
        end
        if (mon_req) chk("busy_stall", {31'b0, stall}, 1);
        if (load_valid) observe(K_LOAD, load_data, 0, 0);
        if (timeout_err) observe(K_TO, 0, 0, 0);
        if (align_err) begin
          chk("reject_stall", {31'b0, stall}, 0);
          observe(K_REJ, 0, 0, 0);
        end
        mon_prev_req = mon_req;
      end
      mon_prev_stall = stall;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
